fmul_arbiter: RTL and testbench

Two-requester round-robin scheduler that shares the single combinational `fmul` unit. It registers the granted requester's operands and mode bits, and captures the `fmul` result one cycle later. It then returns the result on a single tagged response channel with valid/ready backpressure. The block sits between the two issuing units (port 0, port 1) and the one `fmul` instance in the FP datapath.

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fmul.sv | 92 +++++++++
 rtl/fmul_arbiter.sv | 126 ++++++++++++
 tb/tb_fmul_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: arbiter FSM states, canonical special
// encodings, rounding-mode codes and a leading-zero counter for fmul.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NAN_32  = 32'h7FC0_0000;
  localparam logic [31:0] INF_32P = 32'h7F80_0000;
  localparam logic [15:0] NAN_16  = 16'h7E00;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  function automatic logic [5:0] clz48(input logic [47:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd48;
    found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(47 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fmul.sv
// Combinational IEEE-754 multiplier for binary32 or binary16 (low half),
// round-to-nearest-even or round-toward-zero, canonical NaN outputs.
module fmul
  import fp_pkg::*;
(
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mode_fp,
  input  logic        round_mode,
  output logic [31:0] re
);

  logic               sa, sb, sr;
  logic [7:0]         ea, eb, emax;
  logic [22:0]        fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [11:0] bias, ea_u, eb_u, be, under;
  logic [47:0]        prod, pn, mant, mask;
  logic [5:0]         lz, shr;
  logic [24:0]        kept, rounded;
  logic               guard, sticky, sh_sticky, inc, ovf;
  logic [11:0]        base;
  logic [31:0]        fld, exp_val;
  logic [4:0]         fbits;

  always_comb begin
    // Half operands are widened so both formats share one 24-bit significand path.
    if (mode_fp) begin
      sa = op_a[31]; ea = op_a[30:23]; fa = op_a[22:0];
      sb = op_b[31]; eb = op_b[30:23]; fb = op_b[22:0];
      emax = 8'd255; bias = 12'sd127; fbits = 5'd23;
    end else begin
      sa = op_a[15]; ea = {3'b000, op_a[14:10]}; fa = {op_a[9:0], 13'b0};
      sb = op_b[15]; eb = {3'b000, op_b[14:10]}; fb = {op_b[9:0], 13'b0};
      emax = 8'd31; bias = 12'sd15; fbits = 5'd10;
    end
    sr     = sa ^ sb;
    a_zero = (ea == 8'd0) && (fa == 23'd0);
    b_zero = (eb == 8'd0) && (fb == 23'd0);
    a_inf  = (ea == emax) && (fa == 23'd0);
    b_inf  = (eb == emax) && (fb == 23'd0);
    a_nan  = (ea == emax) && (fa != 23'd0);
    b_nan  = (eb == emax) && (fb != 23'd0);
    ea_u   = $signed({4'b0000, (ea == 8'd0) ? 8'd1 : ea}) - bias;
    eb_u   = $signed({4'b0000, (eb == 8'd0) ? 8'd1 : eb}) - bias;

    prod = 48'({ea != 8'd0, fa}) * 48'({eb != 8'd0, fb});
    lz   = clz48(prod);
    pn   = prod << lz;
    be   = ea_u + eb_u + 12'sd1 - $signed({6'b0, lz}) + bias;

    // Tiny results are denormalised before rounding so the sticky bit sees every lost bit.
    under = 12'sd1 - be;
    if (be < 12'sd1) shr = (under > 12'sd48) ? 6'd48 : under[5:0];
    else             shr = 6'd0;
    mask      = (48'd1 << shr) - 48'd1;
    mant      = pn >> shr;
    sh_sticky = |(pn & mask);

    if (mode_fp) begin
      kept   = {1'b0, mant[47:24]};
      guard  = mant[23];
      sticky = (|mant[22:0]) | sh_sticky;
    end else begin
      kept   = {14'b0, mant[47:37]};
      guard  = mant[36];
      sticky = (|mant[35:0]) | sh_sticky;
    end
    inc     = (round_mode == RM_RNE) && guard && (sticky || kept[0]);
    rounded = kept + {24'b0, inc};

    // Adding the significand with its hidden bit onto (exp-1) lets rounding carries ripple into the exponent.
    base    = (be >= 12'sd1) ? $unsigned(be - 12'sd1) : 12'd0;
    fld     = ({20'b0, base} << fbits) + {7'b0, rounded};
    exp_val = fld >> fbits;
    ovf     = exp_val >= {24'b0, emax};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      re = mode_fp ? NAN_32 : {16'b0, NAN_16};
    else if (a_inf || b_inf)
      re = mode_fp ? {sr, INF_32P[30:0]} : {16'b0, sr, 5'h1F, 10'b0};
    else if (a_zero || b_zero)
      re = mode_fp ? {sr, 31'b0} : {16'b0, sr, 15'b0};
    else if (ovf && round_mode == RM_RNE)
      re = mode_fp ? {sr, INF_32P[30:0]} : {16'b0, sr, 5'h1F, 10'b0};
    else if (ovf)
      re = mode_fp ? {sr, 8'hFE, 23'h7FFFFF} : {16'b0, sr, 5'h1E, 10'h3FF};
    else
      re = mode_fp ? {sr, fld[30:0]} : {16'b0, sr, fld[14:0]};
  end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one combinational fmul between two requesters,
// returning tagged results over a single valid/ready response channel.
module fmul_arbiter
  import fp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_op_a0,
  input  logic [W-1:0] req_op_b0,
  input  logic [W-1:0] req_op_a1,
  input  logic [W-1:0] req_op_b1,
  input  logic [1:0]   req_mode_fp,
  input  logic [1:0]   req_round_mode,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_data,
  output logic         busy,
  output logic [15:0]  ops_done0,
  output logic [15:0]  ops_done1
);

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         id_q, id_d;
  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic         mode_fp_q, mode_fp_d, round_mode_q, round_mode_d;
  logic [15:0]  ops_done0_q, ops_done0_d, ops_done1_q, ops_done1_d;
  logic         gnt_vld, gnt_id;
  logic [W-1:0] fmul_re;

  fmul u_fmul (
    .op_a       (op_a_q),
    .op_b       (op_b_q),
    .mode_fp    (mode_fp_q),
    .round_mode (round_mode_q),
    .re         (fmul_re)
  );

  // A lone requester always wins; on a tie the one not served last goes.
  always_comb begin
    gnt_vld = req_valid != 2'b00;
    gnt_id  = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      mode_fp_q    <= 1'b0;
      round_mode_q <= 1'b0;
      res_q        <= '0;
      ops_done0_q  <= 16'd0;
      ops_done1_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      mode_fp_q    <= mode_fp_d;
      round_mode_q <= round_mode_d;
      res_q        <= res_d;
      ops_done0_q  <= ops_done0_d;
      ops_done1_q  <= ops_done1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    mode_fp_d    = mode_fp_q;
    round_mode_d = round_mode_q;
    res_d        = res_q;
    ops_done0_d  = ops_done0_q;
    ops_done1_d  = ops_done1_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d      = EXEC;
          op_a_d       = gnt_id ? req_op_a1 : req_op_a0;
          op_b_d       = gnt_id ? req_op_b1 : req_op_b0;
          mode_fp_d    = req_mode_fp[gnt_id];
          round_mode_d = req_round_mode[gnt_id];
          id_d         = gnt_id;
          last_grant_d = gnt_id;
        end
      end
      EXEC: begin
        res_d   = fmul_re;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          if (id_q) ops_done1_d = ops_done1_q + 16'd1;
          else      ops_done0_d = ops_done0_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && gnt_vld) req_ready = gnt_id ? 2'b10 : 2'b01;
    resp_valid = state_q == RESP;
    resp_data  = resp_valid ? res_q : '0;
    resp_id    = resp_valid & id_q;
    busy       = state_q != IDLE;
  end

  assign ops_done0 = ops_done0_q;
  assign ops_done1 = ops_done1_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed and random checks of fmul_arbiter against a transaction-level
// reference: round-robin grant choice, response timing, data and counters.
module tb_fmul_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_mode_fp, req_round_mode;
  logic [31:0] req_op_a0, req_op_b0, req_op_a1, req_op_b1, resp_data;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [15:0] ops_done0, ops_done1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_res [2];

  bit          m_pend;
  int          m_age;
  bit          m_last;
  bit          m_id;
  logic [31:0] m_data;
  logic [15:0] m_cnt [2];
  logic [15:0] saved1;

  always #5 clk = ~clk;

  fmul_arbiter #(.W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op_a0      (req_op_a0),
    .req_op_b0      (req_op_b0),
    .req_op_a1      (req_op_a1),
    .req_op_b1      (req_op_b1),
    .req_mode_fp    (req_mode_fp),
    .req_round_mode (req_round_mode),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_data      (resp_data),
    .busy           (busy),
    .ops_done0      (ops_done0),
    .ops_done1      (ops_done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit winner(input logic [1:0] v, input bit last);
    if (v == 2'b11) return !last;
    return v[1];
  endfunction

  // Exact encoding of a signed integer magnitude in binary32 or binary16.
  function automatic logic [31:0] to_fp(input bit sp, input bit s, input int unsigned mag);
    int p;
    if (mag == 0) return sp ? {s, 31'b0} : {16'b0, s, 15'b0};
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    if (sp) return {s, 8'(127 + p), 23'((mag << (23 - p)) & 32'h7FFFFF)};
    return {16'b0, s, 5'(15 + p), 10'((mag << (10 - p)) & 32'h3FF)};
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_age = 0; m_last = 1'b1; m_id = 1'b0; m_data = '0;
    m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input bit fp, input bit rm, input logic [31:0] e);
    if (p == 0) begin req_op_a0 = a; req_op_b0 = b; end
    else        begin req_op_a1 = a; req_op_b1 = b; end
    req_mode_fp[p]    = fp;
    req_round_mode[p] = rm;
    exp_res[p]        = e;
  endtask

  task automatic rand_port(input int p);
    bit fp, sa, sb, rm;
    int unsigned lim, ma, mb;
    fp  = 1'($urandom_range(0, 1));
    rm  = 1'($urandom_range(0, 1));
    sa  = 1'($urandom_range(0, 1));
    sb  = 1'($urandom_range(0, 1));
    lim = fp ? 1000 : 40;
    ma  = $urandom_range(0, lim);
    mb  = $urandom_range(0, lim);
    set_port(p, to_fp(fp, sa, ma), to_fp(fp, sb, mb), fp, rm, to_fp(fp, sa ^ sb, ma * mb));
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0] er;
    bit         ev;
    er = 2'b00;
    if (!m_pend && req_valid != 2'b00) er = winner(req_valid, m_last) ? 2'b10 : 2'b01;
    ev = m_pend && (m_age >= 2);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(er));
    chk({tag, ".busy"}, 32'(busy), 32'(m_pend));
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(ev));
    if (ev) begin
      chk({tag, ".resp_data"}, resp_data, m_data);
      chk({tag, ".resp_id"}, 32'(resp_id), 32'(m_id));
    end
    chk({tag, ".ops_done0"}, 32'(ops_done0), 32'(m_cnt[0]));
    chk({tag, ".ops_done1"}, 32'(ops_done1), 32'(m_cnt[1]));
  endtask

  task automatic model_update();
    bit g;
    if (!m_pend) begin
      if (req_valid != 2'b00) begin
        g      = winner(req_valid, m_last);
        m_pend = 1'b1; m_age = 1; m_id = g; m_last = g; m_data = exp_res[g];
      end
    end else if (m_age >= 2 && resp_ready) begin
      m_pend = 1'b0;
      m_cnt[m_id] = m_cnt[m_id] + 16'd1;
    end else if (m_age < 2) begin
      m_age++;
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
    req_op_a0 = '0; req_op_b0 = '0; req_op_a1 = '0; req_op_b1 = '0;
    req_mode_fp = 2'b00; req_round_mode = 2'b00;
    exp_res[0] = '0; exp_res[1] = '0;
    #2;
    do_reset();

    // Single request: 1.0 x 2.0 on port 0.
    resp_ready = 1'b1;
    set_port(0, 32'h3F800000, 32'h40000000, 1'b1, 1'b1, 32'h40000000);
    req_valid = 2'b01;
    step("single");
    req_valid = 2'b00;
    repeat (3) step("single");
    chk("single.count", 32'(ops_done0), 32'd1);

    // Tie from reset, then alternation while both stay valid.
    do_reset();
    set_port(0, 32'h7F800000, 32'h00000000, 1'b1, 1'b0, 32'h7FC00000);
    set_port(1, 32'hBF800000, 32'hBF800000, 1'b1, 1'b0, 32'h3F800000);
    req_valid = 2'b11;
    repeat (9) step("tie");
    req_valid = 2'b00;
    repeat (3) step("tie");

    // Backpressure with both requesters pushing during the stall.
    rand_port(0);
    req_valid = 2'b01;
    step("bp");
    req_valid = 2'b11; resp_ready = 1'b0;
    repeat (6) step("bp");
    resp_ready = 1'b1; req_valid = 2'b00;
    repeat (2) step("bp");

    // Half precision on port 1.
    set_port(1, 32'h00003C00, 32'h00004000, 1'b0, 1'b0, 32'h00004000);
    req_valid = 2'b10;
    step("half");
    req_valid = 2'b00;
    repeat (2) step("half");
    set_port(1, 32'h00007C00, 32'h00000000, 1'b0, 1'b0, 32'h00007E00);
    req_valid = 2'b10;
    step("half_nan");
    req_valid = 2'b00;
    repeat (2) step("half_nan");

    // Reset while the granted operation is in EXEC.
    rand_port(0);
    req_valid = 2'b01;
    step("rst_mid");
    req_valid = 2'b00;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid.ops_done0", 32'(ops_done0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) step("rst_after");

    // Random traffic with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      rand_port(0);
      rand_port(1);
      req_valid  = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end
    req_valid = 2'b00; resp_ready = 1'b1;
    repeat (3) step("drain");

    // Counter wrap: preload 0xFFFF, then one more port-0 completion.
    saved1 = ops_done1;
    force dut.ops_done0_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.ops_done0_q;
    m_cnt[0] = 16'hFFFF;
    rand_port(0);
    req_valid = 2'b01;
    step("wrap");
    req_valid = 2'b00;
    repeat (3) step("wrap");
    chk("wrap.ops_done0", 32'(ops_done0), 32'h0000);
    chk("wrap.ops_done1", 32'(ops_done1), 32'(saved1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
